// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-bit direction, atomic set/clear/toggle writes,
// synchronised inputs, rise/fall edge capture into sticky EVENT bits and an irq.

module gpio_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic gclk,
    input  logic reset,
    input  logic pin,
    input  logic rise_en,
    input  logic fall_en,
    input  logic ev_clr,
    output logic in_bit,
    output logic ev_bit
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   hit;

    assign in_bit = sync[SYNC_STAGES-1];
    assign hit    = (in_bit & ~prev & rise_en) | (~in_bit & prev & fall_en);

    // A new edge beats a coincident write-1-to-clear on the same bit.
    always_ff @(posedge gclk) begin
        if (reset) begin
            sync   <= '0;
            prev   <= 1'b0;
            ev_bit <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pin};
            prev   <= in_bit;
            ev_bit <= (ev_bit & ~ev_clr) | hit;
        end
    end
endmodule

module gpio_bank #(
    parameter logic [15:0] OFFSET      = 16'h8100,
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [15:0]      read_addr,
    output logic [15:0]      read_data,
    input  logic [15:0]      write_addr,
    input  logic [15:0]      write_data,
    input  logic             write_strobe,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] output_pins,
    output logic [WIDTH-1:0] o_output_enable,
    output logic             o_irq
);
    typedef enum logic [3:0] {
        R_OUT = 4'd0, R_SET = 4'd1, R_CLR = 4'd2, R_TGL = 4'd3, R_DIR = 4'd4,
        R_IN  = 4'd5, R_REN = 4'd6, R_FEN = 4'd7, R_EVT = 4'd8
    } reg_idx_t;

    logic [WIDTH-1:0] out_q, dir_q, ren_q, fen_q;
    logic [WIDTH-1:0] in_v, ev_v, ev_clr;
    logic [WIDTH-1:0] wdata;
    logic             wr_en, rd_sel;
    logic [15:0]      rd_val;

    assign wr_en  = write_strobe && (write_addr[15:4] == OFFSET[15:4]);
    assign rd_sel = (read_addr[15:4] == OFFSET[15:4]);
    assign wdata  = write_data[WIDTH-1:0];
    assign ev_clr = (wr_en && write_addr[3:0] == R_EVT) ? wdata : '0;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            gpio_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .gclk    (i_clk),
                .reset   (i_reset),
                .pin     (i_pins[g]),
                .rise_en (ren_q[g]),
                .fall_en (fen_q[g]),
                .ev_clr  (ev_clr[g]),
                .in_bit  (in_v[g]),
                .ev_bit  (ev_v[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q <= '0;
            dir_q <= '0;
            ren_q <= '0;
            fen_q <= '0;
        end else if (wr_en) begin
            case (write_addr[3:0])
                R_OUT:   out_q <= wdata;
                R_SET:   out_q <= out_q | wdata;
                R_CLR:   out_q <= out_q & ~wdata;
                R_TGL:   out_q <= out_q ^ wdata;
                R_DIR:   dir_q <= wdata;
                R_REN:   ren_q <= wdata;
                R_FEN:   fen_q <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = 16'h0000;
        case (read_addr[3:0])
            R_OUT, R_SET, R_CLR, R_TGL: rd_val = 16'(out_q);
            R_DIR:   rd_val = 16'(dir_q);
            R_IN:    rd_val = 16'(in_v);
            R_REN:   rd_val = 16'(ren_q);
            R_FEN:   rd_val = 16'(fen_q);
            R_EVT:   rd_val = 16'(ev_v);
            default: rd_val = 16'h0000;
        endcase
    end

    // Read data is zero when unselected so it can be OR-combined on the bus.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            read_data <= 16'h0000;
            o_irq     <= 1'b0;
        end else begin
            read_data <= rd_sel ? rd_val : 16'h0000;
            o_irq     <= |ev_v;
        end
    end

    assign output_pins     = out_q;
    assign o_output_enable = dir_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Randomised + directed bench for gpio_bank against a register-level model.

module tb_gpio_bank;
    localparam logic [15:0] OFF = 16'h8100;
    localparam int W = 8;
    localparam int S = 2;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [15:0]   read_addr = 16'h0, write_addr = 16'h0, write_data = 16'h0;
    logic          write_strobe = 1'b0;
    logic [W-1:0]  i_pins = '0;
    logic [15:0]   read_data;
    logic [W-1:0]  output_pins, o_output_enable;
    logic          o_irq;

    gpio_bank #(.OFFSET(OFF), .WIDTH(W), .SYNC_STAGES(S)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .read_addr       (read_addr),
        .read_data       (read_data),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_strobe    (write_strobe),
        .i_pins          (i_pins),
        .output_pins     (output_pins),
        .o_output_enable (o_output_enable),
        .o_irq           (o_irq)
    );

    always #5 i_clk = ~i_clk;

    // Model: register values plus the history of pin levels sampled at each edge.
    logic [W-1:0] m_out = '0, m_dir = '0, m_ren = '0, m_fen = '0, m_ev = '0;
    logic         m_irq = 1'b0;
    logic [15:0]  m_rd = 16'h0;
    logic [W-1:0] hist [0:S];
    int n_chk = 0, n_fail = 0;

    function automatic bit in_win(logic [15:0] a);
        return a[15:4] == OFF[15:4];
    endfunction

    // IN after edge n is the pin level sampled at edge n-S+1, i.e. hist[S-1].
    function automatic logic [15:0] m_reg(logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3: return 16'(m_out);
            4'd4: return 16'(m_dir);
            4'd5: return 16'(hist[S-1]);
            4'd6: return 16'(m_ren);
            4'd7: return 16'(m_fen);
            4'd8: return 16'(m_ev);
            default: return 16'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] rise, fall, wd, ev_n;
        if (i_reset) begin
            m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_ev = '0;
            m_irq = 1'b0; m_rd = 16'h0;
            for (int i = 0; i <= S; i++) hist[i] = '0;
        end else begin
            m_rd  = in_win(read_addr) ? m_reg(read_addr[3:0]) : 16'h0;
            m_irq = |m_ev;
            rise  = hist[S-1] & ~hist[S] & m_ren;
            fall  = ~hist[S-1] & hist[S] & m_fen;
            wd    = write_data[W-1:0];
            ev_n  = m_ev;
            if (write_strobe && in_win(write_addr)) begin
                case (write_addr[3:0])
                    4'd0: m_out = wd;
                    4'd1: m_out = m_out | wd;
                    4'd2: m_out = m_out & ~wd;
                    4'd3: m_out = m_out ^ wd;
                    4'd4: m_dir = wd;
                    4'd6: m_ren = wd;
                    4'd7: m_fen = wd;
                    4'd8: ev_n  = m_ev & ~wd;
                    default: ;
                endcase
            end
            m_ev = ev_n | rise | fall;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = i_pins;
        end
    endtask

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("read_data", read_data, m_rd);
        chk("output_pins", 16'(output_pins), 16'(m_out));
        chk("output_enable", 16'(o_output_enable), 16'(m_dir));
        chk("irq", 16'(o_irq), 16'(m_irq));
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        compare();
    endtask

    task automatic wr(logic [3:0] idx, logic [15:0] d);
        write_addr   = OFF + {12'h0, idx};
        write_data   = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    initial begin
        for (int i = 0; i <= S; i++) hist[i] = '0;

        // Reset and read the whole window
        i_reset = 1'b1;
        tick(); tick();
        i_reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_addr = OFF + 16'(i);
            tick();
            chk("lit_reset_read", read_data, 16'h0000);
        end
        chk("lit_reset_pins", 16'(output_pins), 16'h0);
        chk("lit_reset_oe", 16'(o_output_enable), 16'h0);
        chk("lit_reset_irq", 16'(o_irq), 16'h0);

        // OUT / SET / CLR / TGL
        wr(4'd0, 16'h00A5); chk("lit_out", 16'(output_pins), 16'h00A5);
        wr(4'd1, 16'h0F00); chk("lit_set", 16'(output_pins), 16'h00A5);
        wr(4'd2, 16'h0005); chk("lit_clr", 16'(output_pins), 16'h00A0);
        wr(4'd3, 16'h00FF); chk("lit_tgl", 16'(output_pins), 16'h005F);
        read_addr = OFF;
        tick(); chk("lit_read_out", read_data, 16'h005F);

        // Rising edge on pin 0
        wr(4'd6, 16'h0001);
        read_addr = OFF + 16'd5;
        i_pins = 8'h01;
        tick(); chk("lit_irq_k", 16'(o_irq), 16'h0);
        tick();
        tick(); chk("lit_in_k2", read_data, 16'h0001);
        chk("lit_irq_k2", 16'(o_irq), 16'h0);
        tick(); chk("lit_irq_k3", 16'(o_irq), 16'h1);
        // Falling edge with FALL_EN=0
        i_pins = 8'h00;
        read_addr = OFF + 16'd8;
        repeat (4) tick();
        chk("lit_no_fall_ev", read_data, 16'h0001);

        // W1C, then clear colliding with a new rise
        wr(4'd6, 16'h0003);
        i_pins = 8'h03;
        repeat (4) tick();
        chk("lit_ev3", read_data, 16'h0003);
        wr(4'd8, 16'h0001);
        tick(); chk("lit_w1c", read_data, 16'h0002);
        chk("lit_w1c_irq", 16'(o_irq), 16'h1);
        i_pins = 8'h01;
        repeat (4) tick();
        i_pins = 8'h03;
        tick(); tick();
        wr(4'd8, 16'h0002);
        tick(); chk("lit_set_wins", read_data, 16'h0002);

        // Decode
        read_addr = OFF + 16'd16;
        tick(); chk("lit_rd_next_win", read_data, 16'h0000);
        read_addr = 16'h0000;
        tick(); chk("lit_rd_zero", read_data, 16'h0000);
        wr(4'd9, 16'hFFFF); chk("lit_wr9", 16'(output_pins), 16'h005F);
        read_addr = OFF;
        wr(4'd0, 16'h0012); chk("lit_rd_old", read_data, 16'h005F);
        tick(); chk("lit_rd_new", read_data, 16'h0012);

        // Reset mid-operation
        wr(4'd0, 16'h00FF);
        i_pins = 8'h00;
        tick();
        i_reset = 1'b1;
        tick();
        chk("lit_rst_rd", read_data, 16'h0);
        chk("lit_rst_pins", 16'(output_pins), 16'h0);
        chk("lit_rst_oe", 16'(o_output_enable), 16'h0);
        chk("lit_rst_irq", 16'(o_irq), 16'h0);
        i_reset = 1'b0;
        read_addr = OFF + 16'd8;
        i_pins = 8'hFF;
        repeat (S + 2) begin
            tick();
            chk("lit_post_rst_ev", read_data, 16'h0);
            chk("lit_post_rst_irq", 16'(o_irq), 16'h0);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            i_reset      = ($urandom_range(0, 99) == 0);
            write_strobe = $urandom_range(0, 1) == 1;
            write_addr   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : OFF + 16'($urandom_range(0, 15));
            read_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : OFF + 16'($urandom_range(0, 15));
            write_data   = 16'($urandom);
            if ($urandom_range(0, 2) == 0) i_pins = i_pins ^ W'($urandom);
            tick();
        end
        write_strobe = 1'b0;
        i_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
